// File: rtl/program_load_controller.sv
// program_load_controller
//   Host-side sequencer for the CPU datapath's load/debug port. Packs a
//   little-endian byte stream into 32-bit instruction words and strobes them
//   into instruction RAM while holding the datapath in reset. Afterwards it
//   gates debug_enable for RUN, HALT and fixed-length STEP commands, and keeps
//   a saturating count of enabled cycles since the last LOAD.
module program_load_controller #(
  parameter int MAX_WORDS   = 256,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_WIDTH   = 32,
  localparam int WCW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  input  logic [WCW-1:0]       cmd_len,
  output logic                 cmd_ready,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 instruction_write,
  output logic [31:0]          instruction_in,
  output logic                 debug_enable,
  output logic                 cpu_rst,
  output logic [WCW-1:0]       word_count,
  output logic [CNT_WIDTH-1:0] run_cycles,
  output logic                 error
);

  localparam int SCW = $clog2(STEP_CYCLES + 1);

  localparam logic [WCW-1:0]       MAX_LEN   = WCW'(MAX_WORDS);
  localparam logic [WCW-1:0]       WC_ONE    = WCW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [SCW-1:0]       STEP_LOAD = SCW'(STEP_CYCLES);
  localparam logic [SCW-1:0]       SC_ONE    = SCW'(1);

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HALT,
    S_RUN,
    S_STEP
  } state_t;

  state_t         state;
  logic [WCW-1:0] len_q;
  logic [1:0]     byte_idx;
  logic [23:0]    word_buf;   // bytes 0..2 of the word being assembled
  logic [SCW-1:0] step_cnt;

  logic           cmd_fire;
  logic           byte_fire;
  logic           len_ok;
  logic           load_start;
  logic [WCW-1:0] wc_next;

  // Handshake decode; the ready flags are registered, so these are glitch-free.
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign byte_fire  = byte_valid && byte_ready && (state == S_LOAD);
  assign len_ok     = (cmd_len != '0) && (cmd_len <= MAX_LEN);
  assign load_start = cmd_fire && (cmd == CMD_LOAD) && len_ok;
  assign wc_next    = word_count + WC_ONE;

  // Registered per-state outputs, packed as {cpu_rst, debug_enable, cmd_ready, byte_ready}.
  // Every transition loads these together with the new state so outputs change
  // on the same edge as the state itself.
  function automatic logic [3:0] state_outputs(input state_t s);
    case (s)
      S_IDLE:  state_outputs = 4'b1010;
      S_LOAD:  state_outputs = 4'b1001;
      S_HALT:  state_outputs = 4'b0010;
      S_RUN:   state_outputs = 4'b0110;
      S_STEP:  state_outputs = 4'b0100;
      default: state_outputs = 4'b1010;
    endcase
  endfunction

  // Control FSM with load datapath: command decode, byte packing, write strobe, step timing.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; a blocking write would leak into later reads in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_IDLE);
      instruction_write <= 1'b0;
      instruction_in    <= '0;
      word_count        <= '0;
      len_q             <= '0;
      byte_idx          <= '0;
      // NOTE: the partial-word buffer is reset too, so a load aborted by reset
      // can never leak stale bytes into the next program.
      word_buf          <= '0;
      step_cnt          <= '0;
      error             <= 1'b0;
    end else begin
      instruction_write <= 1'b0;

      // Commands only fire in IDLE, HALT and RUN (cmd_ready is low elsewhere).
      if (cmd_fire) begin
        if (cmd == CMD_LOAD) begin
          if (len_ok) begin
            state      <= S_LOAD;
            {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_LOAD);
            len_q      <= cmd_len;
            word_count <= '0;
            byte_idx   <= '0;
            error      <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end else begin
          case (state)
            S_IDLE: error <= 1'b1;  // nothing loaded yet: RUN/STEP/HALT are illegal
            S_HALT: begin
              if (cmd == CMD_RUN) begin
                state <= S_RUN;
                {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_RUN);
              end else if (cmd == CMD_STEP) begin
                state    <= S_STEP;
                {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_STEP);
                step_cnt <= STEP_LOAD;
              end
            end
            S_RUN: begin
              if (cmd != CMD_RUN) begin
                state <= S_HALT;
                {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_HALT);
              end
            end
            default: ;
          endcase
        end
      end

      // Byte packing: bytes 0..2 are buffered, byte 3 completes and writes the word.
      if (byte_fire) begin
        case (byte_idx)
          2'd0: word_buf[7:0]   <= byte_data;
          2'd1: word_buf[15:8]  <= byte_data;
          2'd2: word_buf[23:16] <= byte_data;
          default: begin
            instruction_in    <= {byte_data, word_buf};
            instruction_write <= 1'b1;
            word_count        <= wc_next;
            if (wc_next == len_q) begin
              state <= S_HALT;
              {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_HALT);
            end
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end

      // STEP holds debug_enable for exactly STEP_CYCLES cycles, then halts.
      if (state == S_STEP) begin
        step_cnt <= step_cnt - SC_ONE;
        if (step_cnt == SC_ONE) begin
          state <= S_HALT;
          {cpu_rst, debug_enable, cmd_ready, byte_ready} <= state_outputs(S_HALT);
        end
      end
    end
  end

  // Saturating count of enabled cycles; a successful LOAD restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (load_start) begin
      run_cycles <= '0;
    end else if (debug_enable && (run_cycles != '1)) begin
      run_cycles <= run_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_program_load_controller.sv
// tb_program_load_controller
//   Scenario bench for program_load_controller. Expected instruction words are
//   queued as bytes are driven and popped by a monitor on each write strobe.
//   CNT_WIDTH is 4 so counter saturation is reachable in a few cycles.
module tb_program_load_controller;

  localparam int MAX_WORDS   = 256;
  localparam int STEP_CYCLES = 1;
  localparam int CNT_WIDTH   = 4;
  localparam int WCW         = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_STEP = 2'b10;
  localparam logic [1:0] C_HALT = 2'b11;

  // Flag vector {cpu_rst, debug_enable, cmd_ready, byte_ready, instruction_write, error}
  localparam logic [5:0] F_IDLE      = 6'b101000;
  localparam logic [5:0] F_IDLE_ERR  = 6'b101001;
  localparam logic [5:0] F_LOAD      = 6'b100100;
  localparam logic [5:0] F_HALT      = 6'b001000;
  localparam logic [5:0] F_HALT_ERR  = 6'b001001;
  localparam logic [5:0] F_HALT_WR   = 6'b001010;
  localparam logic [5:0] F_RUN       = 6'b011000;
  localparam logic [5:0] F_STEP      = 6'b010000;

  logic                 clk;
  logic                 rst;
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic [WCW-1:0]       cmd_len;
  logic                 cmd_ready;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 instruction_write;
  logic [31:0]          instruction_in;
  logic                 debug_enable;
  logic                 cpu_rst;
  logic [WCW-1:0]       word_count;
  logic [CNT_WIDTH-1:0] run_cycles;
  logic                 error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  int          n_writes  = 0;
  int          en_cycles = 0;
  time         t_prev    = 0;
  time         t_last    = 0;
  logic [5:0]  flags;

  program_load_controller #(
    .MAX_WORDS  (MAX_WORDS),
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd              (cmd),
    .cmd_len          (cmd_len),
    .cmd_ready        (cmd_ready),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .instruction_write(instruction_write),
    .instruction_in   (instruction_in),
    .debug_enable     (debug_enable),
    .cpu_rst          (cpu_rst),
    .word_count       (word_count),
    .run_cycles       (run_cycles),
    .error            (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign flags = {cpu_rst, debug_enable, cmd_ready, byte_ready, instruction_write, error};

  // Monitor: counts enabled cycles and checks every write strobe against the scoreboard.
  always @(negedge clk) begin
    if (debug_enable) en_cycles++;
    if (instruction_write) begin
      n_writes++;
      t_prev = t_last;
      t_last = $time;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got instruction_in=%08h, expected no write", instruction_in);
      end else begin
        exp_w = exp_q.pop_front();
        if (instruction_in !== exp_w) begin
          n_fail++;
          $display("FAIL write_data: got %08h, expected %08h", instruction_in, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Issue one command; called and returns at a falling edge, accepted at the rising edge between.
  task automatic send_cmd(input logic [1:0] c, input int len);
    int waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_timeout: cmd_ready=%b, expected 1 within 100 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_len   = WCW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Present one byte for one cycle; byte_valid stays high for back-to-back streaming.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (!byte_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!byte_ready) begin
      n_fail++;
      $display("FAIL byte_timeout: byte_ready=%b, expected 1 within 100 cycles", byte_ready);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = C_LOAD; cmd_len = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    if (flags !== F_IDLE) begin
      n_fail++; $display("FAIL reset_flags_in_reset: got %b, expected %b", flags, F_IDLE);
    end
    n_checks++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (flags !== F_IDLE || instruction_in !== 32'h0 || word_count !== '0 || run_cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_values: flags=%b instr=%08h wc=%0d rc=%0d, expected %b 00000000 0 0",
               flags, instruction_in, word_count, run_cycles, F_IDLE);
    end
  endtask

  task automatic test_load_basic();
    int w0 = n_writes;
    send_cmd(C_LOAD, 2);
    n_checks++;
    if (flags !== F_LOAD || word_count !== '0) begin
      n_fail++; $display("FAIL load_enter: flags=%b wc=%0d, expected %b 0", flags, word_count, F_LOAD);
    end
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    byte_valid = 1'b0;
    // One cycle after the final byte handshake: strobe high, already in HALT.
    n_checks++;
    if (flags !== F_HALT_WR || word_count !== WCW'(2)) begin
      n_fail++; $display("FAIL load_done: flags=%b wc=%0d, expected %b 2", flags, word_count, F_HALT_WR);
    end
    @(negedge clk);
    n_checks++;
    if (instruction_write !== 1'b0 || n_writes - w0 != 2) begin
      n_fail++;
      $display("FAIL write_strobe_count: write=%b writes=%0d, expected 0 2", instruction_write, n_writes - w0);
    end
    n_checks++;
    if (t_last - t_prev != 40) begin
      n_fail++; $display("FAIL word_throughput: spacing=%0t, expected 40", t_last - t_prev);
    end
  endtask

  task automatic test_run();
    int e0 = en_cycles;
    send_cmd(C_RUN, 0);
    n_checks++;
    if (flags !== F_RUN) begin
      n_fail++; $display("FAIL run_flags: got %b, expected %b", flags, F_RUN);
    end
    repeat (9) @(negedge clk);
    send_cmd(C_HALT, 0);
    n_checks++;
    if (flags !== F_HALT) begin
      n_fail++; $display("FAIL halt_flags: got %b, expected %b", flags, F_HALT);
    end
    n_checks++;
    if (en_cycles - e0 != 10 || run_cycles !== CNT_WIDTH'(10)) begin
      n_fail++;
      $display("FAIL run_length: en_cycles=%0d run_cycles=%0d, expected 10 10", en_cycles - e0, run_cycles);
    end
  endtask

  task automatic test_step();
    for (int s = 0; s < 2; s++) begin
      int e0 = en_cycles;
      send_cmd(C_STEP, 0);
      n_checks++;
      if (flags !== F_STEP) begin
        n_fail++; $display("FAIL step_pulse_flags: got %b, expected %b", flags, F_STEP);
      end
      @(negedge clk);
      n_checks++;
      if (flags !== F_HALT || en_cycles - e0 != 1) begin
        n_fail++;
        $display("FAIL step_end: flags=%b en_cycles=%0d, expected %b 1", flags, en_cycles - e0, F_HALT);
      end
    end
    n_checks++;
    if (run_cycles !== CNT_WIDTH'(12)) begin
      n_fail++; $display("FAIL step_run_cycles: got %0d, expected 12", run_cycles);
    end
  endtask

  task automatic test_bad_len();
    send_cmd(C_LOAD, 0);
    n_checks++;
    if (flags !== F_HALT_ERR || word_count !== WCW'(2)) begin
      n_fail++; $display("FAIL len_zero: flags=%b wc=%0d, expected %b 2", flags, word_count, F_HALT_ERR);
    end
    send_cmd(C_LOAD, MAX_WORDS + 1);
    n_checks++;
    if (flags !== F_HALT_ERR || word_count !== WCW'(2)) begin
      n_fail++; $display("FAIL len_over: flags=%b wc=%0d, expected %b 2", flags, word_count, F_HALT_ERR);
    end
  endtask

  task automatic test_max_load();
    send_cmd(C_LOAD, MAX_WORDS);
    n_checks++;
    if (flags !== F_LOAD || run_cycles !== '0) begin
      n_fail++; $display("FAIL max_load_enter: flags=%b rc=%0d, expected %b 0", flags, run_cycles, F_LOAD);
    end
    for (int i = 0; i < MAX_WORDS; i++) send_word($urandom);
    byte_valid = 1'b0;
    n_checks++;
    if (flags !== F_HALT_WR || word_count !== WCW'(MAX_WORDS)) begin
      n_fail++;
      $display("FAIL max_load_done: flags=%b wc=%0d, expected %b %0d", flags, word_count, F_HALT_WR, MAX_WORDS);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    int w0;
    send_cmd(C_LOAD, 4);
    send_word(32'hA1B2_C3D4);
    send_word(32'h0102_0304);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    w0 = n_writes;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (flags !== F_IDLE || instruction_in !== 32'h0 || word_count !== '0 || run_cycles !== '0) begin
      n_fail++;
      $display("FAIL mid_load_reset: flags=%b instr=%08h wc=%0d rc=%0d, expected %b 00000000 0 0",
               flags, instruction_in, word_count, run_cycles, F_IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (n_writes != w0 || flags !== F_IDLE) begin
      n_fail++; $display("FAIL no_write_after_reset: writes=%0d flags=%b, expected 0 %b", n_writes - w0, flags, F_IDLE);
    end
    send_cmd(C_RUN, 0);
    n_checks++;
    if (flags !== F_IDLE_ERR) begin
      n_fail++; $display("FAIL idle_illegal_cmd: got %b, expected %b", flags, F_IDLE_ERR);
    end
    send_cmd(C_LOAD, 1);
    n_checks++;
    if (flags !== F_LOAD) begin
      n_fail++; $display("FAIL reload_enter: got %b, expected %b", flags, F_LOAD);
    end
    send_word(32'h4433_2211);
    byte_valid = 1'b0;
    n_checks++;
    if (flags !== F_HALT_WR || word_count !== WCW'(1)) begin
      n_fail++; $display("FAIL reload_done: flags=%b wc=%0d, expected %b 1", flags, word_count, F_HALT_WR);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    send_cmd(C_RUN, 0);
    repeat (15) @(negedge clk);
    n_checks++;
    if (run_cycles !== 4'd15) begin
      n_fail++; $display("FAIL sat_reach: got %0d, expected 15", run_cycles);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (run_cycles !== 4'd15 || flags !== F_RUN) begin
      n_fail++; $display("FAIL sat_hold: rc=%0d flags=%b, expected 15 %b", run_cycles, flags, F_RUN);
    end
    send_cmd(C_LOAD, 1);
    n_checks++;
    if (flags !== F_LOAD || run_cycles !== '0 || word_count !== '0) begin
      n_fail++;
      $display("FAIL load_from_run: flags=%b rc=%0d wc=%0d, expected %b 0 0", flags, run_cycles, word_count, F_LOAD);
    end
    send_word(32'hDEAD_BEEF);
    byte_valid = 1'b0;
    n_checks++;
    if (flags !== F_HALT_WR || word_count !== WCW'(1)) begin
      n_fail++; $display("FAIL final_load: flags=%b wc=%0d, expected %b 1", flags, word_count, F_HALT_WR);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_run();
    test_step();
    test_bad_len();
    test_max_load();
    test_reset_mid_load();
    test_saturate();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
